btn_conditioner: RTL and testbench

- Input-side counterpart to the stopwatch display path: turns raw, bouncy push-button levels (start, stop, add, ...) into clean levels and single-cycle press/release pulses.
- The stopwatch state machine consumes these pulses.
- Sits between the board pins and the control FSM, in the same clock domain as the clock divider.
- Debouncing is gated by a sample-enable strobe, so the divider's slow tick sets the debounce time.

---
 rtl/btn_conditioner.sv | 143 ++++++++++++++
 tb/tb_btn_conditioner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Turns raw, bouncy push-button levels into clean debounced levels plus
//   single-cycle press/release pulses for the stopwatch control FSM. Each
//   channel is synchronised (2 flops), then debounced by a counter that only
//   advances on i_sample_en strobes. The divider tick therefore sets the
//   debounce time.
//
//   Optional feature: define BTN_AUTOREPEAT_EN to add per-channel auto-repeat
//   press pulses while a button is held. Without the macro no repeat logic
//   exists and each accepted press yields exactly one press pulse.
//
// Ports
//   i_clk            system clock
//   i_rst            synchronous, active-high reset
//   i_sample_en      debounce sample strobe (tie to 1 for per-clock sampling)
//   i_btn_raw        asynchronous raw button levels, 1 = pressed
//   o_btn_level      debounced level per channel
//   o_press_pulse    one-clk pulse per accepted press (plus repeats if enabled)
//   o_release_pulse  one-clk pulse per accepted release
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int NUM_BTN       = 3,
  parameter int DB_TICKS      = 4,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sample_en,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic [NUM_BTN-1:0] o_press_pulse,
  output logic [NUM_BTN-1:0] o_release_pulse
);

  localparam int CW = $clog2(DB_TICKS + 1);

  // Reject illegal configurations at elaboration rather than building
  // counters that can never reach their terminal count.
  if (DB_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("btn_conditioner: DB_TICKS, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NUM_BTN-1:0] r_s1;
  logic [NUM_BTN-1:0] r_s2;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;
  logic [NUM_BTN-1:0] r_release;
  logic [CW-1:0]      r_db_cnt [NUM_BTN];

  logic [NUM_BTN-1:0] w_accept;   // level toggles on this edge
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] w_fall;
  logic [NUM_BTN-1:0] w_rpt_fire;

  // The new level is accepted on the sampled tick that would take the counter
  // to DB_TICKS, so the counter itself never holds that value and never wraps.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_accept[i] = (r_s2[i] != r_level[i]) && i_sample_en &&
                    (r_db_cnt[i] == CW'(DB_TICKS - 1));
    end
  end

  assign w_rise = w_accept & ~r_level;
  assign w_fall = w_accept &  r_level;

  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      // NOTE: the counter array is small per-channel state, not a RAM, so it
      // is reset along with everything else.
      for (int i = 0; i < NUM_BTN; i++) r_db_cnt[i] <= '0;
    end else begin
      r_s1      <= i_btn_raw;
      r_s2      <= r_s1;
      r_level   <= r_level ^ w_accept;
      r_press   <= w_rise | w_rpt_fire;
      r_release <= w_fall;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (r_s2[i] == r_level[i] || w_accept[i]) begin
          r_db_cnt[i] <= '0;          // agreement or acceptance restarts qualification
        end else if (i_sample_en) begin
          r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0]      r_rpt_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_rpt_phase;  // 0: waiting out REPEAT_DELAY, 1: REPEAT_PERIOD

  // A repeat never fires on the edge that accepts a release.
  always_comb begin
    w_rpt_fire = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_rpt_fire[i] = r_level[i] && !w_fall[i] && i_sample_en &&
                      ((r_rpt_cnt[i] + RW'(1)) ==
                       (r_rpt_phase[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY)));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rpt_phase <= '0;
      for (int i = 0; i < NUM_BTN; i++) r_rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!r_level[i] || w_fall[i]) begin
          r_rpt_cnt[i]   <= '0;
          r_rpt_phase[i] <= 1'b0;
        end else if (w_rpt_fire[i]) begin
          r_rpt_cnt[i]   <= '0;
          r_rpt_phase[i] <= 1'b1;
        end else if (i_sample_en) begin
          r_rpt_cnt[i]   <= r_rpt_cnt[i] + RW'(1);
        end
      end
    end
  end
`else
  assign w_rpt_fire = '0;
`endif

  assign o_btn_level     = r_level;
  assign o_press_pulse   = r_press;
  assign o_release_pulse = r_release;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//   Directed bench for btn_conditioner with NUM_BTN=3, DB_TICKS=4,
//   REPEAT_DELAY=5, REPEAT_PERIOD=3. Inputs are driven and outputs sampled on
//   the falling clock edge. Expected values are hand-derived; with
//   BTN_AUTOREPEAT_EN defined the repeat pulse schedule is added.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  logic       clk;
  logic       rst;
  logic       sample_en;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] press_pulse;
  logic [2:0] release_pulse;

  int tests;
  int fails;

  btn_conditioner #(
    .NUM_BTN       (3),
    .DB_TICKS      (4),
    .REPEAT_DELAY  (5),
    .REPEAT_PERIOD (3)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_sample_en     (sample_en),
    .i_btn_raw       (btn_raw),
    .o_btn_level     (btn_level),
    .o_press_pulse   (press_pulse),
    .o_release_pulse (release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] lvl,
                           input logic [2:0] prs, input logic [2:0] rel);
    check({tag, ".level"},   btn_level,     lvl);
    check({tag, ".press"},   press_pulse,   prs);
    check({tag, ".release"}, release_pulse, rel);
  endtask

  // Repeat pulse expected k sampled ticks after acceptance (delay 5, period 3).
  function automatic logic rpt_exp(input int k);
`ifdef BTN_AUTOREPEAT_EN
    return (k >= 5) && ((k - 5) % 3 == 0);
`else
    return (k < 0);
`endif
  endfunction

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    sample_en = 1'b1;
    btn_raw   = 3'b111;

    // Reset held with all buttons pressed: outputs stay 0.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("reset", 3'b000, 3'b000, 3'b000);
    end
    rst = 1'b0;
    tick();
    check_all("post_reset", 3'b000, 3'b000, 3'b000);

    // Buttons still held: re-qualified from scratch, press after 6 edges.
    ticks(4);
    check_all("requal_wait", 3'b000, 3'b000, 3'b000);
    tick();
    check_all("requal_press", 3'b111, 3'b111, 3'b000);
    tick();
    check_all("requal_hold", 3'b111, 3'b000, 3'b000);
    btn_raw = 3'b000;
    ticks(5);
    check("requal_rel_wait", btn_level, 3'b111);
    tick();
    check("requal_rel_level", btn_level, 3'b000);
    check("requal_rel_pulse", release_pulse, 3'b111);
    tick();
    check_all("requal_idle", 3'b000, 3'b000, 3'b000);

    // Clean press on ch0: level rises exactly 6 edges after the raw edge.
    btn_raw = 3'b001;
    ticks(5);
    check_all("ch0_wait", 3'b000, 3'b000, 3'b000);
    tick();
    check_all("ch0_press", 3'b001, 3'b001, 3'b000);
    tick();
    check_all("ch0_hold", 3'b001, 3'b000, 3'b000);
    btn_raw = 3'b000;
    ticks(5);
    check("ch0_rel_wait", btn_level, 3'b001);
    tick();
    check("ch0_rel_level", btn_level, 3'b000);
    check("ch0_rel_pulse", release_pulse, 3'b001);
    tick();
    check_all("ch0_idle", 3'b000, 3'b000, 3'b000);

    // Bounce on ch1: never stable for 4 sampled ticks, nothing accepted.
    for (int b = 0; b < 4; b++) begin
      btn_raw = (b % 2 == 0) ? 3'b010 : 3'b000;
      for (int i = 0; i < 2; i++) begin
        tick();
        check_all("bounce", 3'b000, 3'b000, 3'b000);
      end
    end
    btn_raw = 3'b000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all("bounce_settle", 3'b000, 3'b000, 3'b000);
    end

    // Gated sampling on ch2: one strobe every 8 clocks, accept on 4th strobe.
    sample_en = 1'b0;
    btn_raw   = 3'b100;
    ticks(2);
    for (int b = 1; b <= 4; b++) begin
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
      if (b < 4) begin
        check_all("gated_strobe", 3'b000, 3'b000, 3'b000);
        ticks(7);
        check_all("gated_hold", 3'b000, 3'b000, 3'b000);
      end else begin
        check_all("gated_press", 3'b100, 3'b100, 3'b000);
      end
    end
    tick();
    check_all("gated_after", 3'b100, 3'b000, 3'b000);
    sample_en = 1'b1;
    btn_raw   = 3'b000;
    ticks(5);
    check("gated_rel_wait", btn_level, 3'b100);
    tick();
    check("gated_rel_level", btn_level, 3'b000);
    check("gated_rel_pulse", release_pulse, 3'b100);
    tick();
    check_all("gated_idle", 3'b000, 3'b000, 3'b000);

    // Simultaneous press/release on ch0 and ch2.
    btn_raw = 3'b101;
    ticks(5);
    check_all("dual_wait", 3'b000, 3'b000, 3'b000);
    tick();
    check_all("dual_press", 3'b101, 3'b101, 3'b000);
    for (int k = 1; k <= 19; k++) begin
      if (k == 15) btn_raw = 3'b000;
      tick();
      check_all("dual_hold", 3'b101, {rpt_exp(k), 1'b0, rpt_exp(k)}, 3'b000);
      if (k == 14) btn_raw = 3'b000;
    end
    tick();
    check_all("dual_release", 3'b000, 3'b000, 3'b101);
    tick();
    check_all("dual_idle", 3'b000, 3'b000, 3'b000);

    // Auto-repeat schedule on ch1 (single pulse without the macro).
    btn_raw = 3'b010;
    ticks(6);
    check_all("rpt_press", 3'b010, 3'b010, 3'b000);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_all("rpt_hold", 3'b010, {1'b0, rpt_exp(k), 1'b0}, 3'b000);
      if (k == 15) btn_raw = 3'b000;
    end
    tick();
    check_all("rpt_release", 3'b000, 3'b000, 3'b010);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("rpt_idle", 3'b000, 3'b000, 3'b000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
